// File: rtl/alu_program_sequencer.sv
// Stored-program accumulator machine: instruction memory, pc, acc/carry and IDLE/FETCH/EXEC control.
// Optional macro SEQ_BRANCH_EN enables JMP/JC; without it those opcodes decode as NOP.
module alu_program_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [DATA_W+3:0]   prog_data,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   acc_out,
  output logic                carry_out,
  output logic [ADDR_W-1:0]   pc_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IW    = DATA_W + 4;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IW-1:0]       mem_r [DEPTH];
  logic [IW-1:0]       ir_r;
  logic [3:0]          op_s;
  logic [DATA_W-1:0]   imm_s;
  logic [DATA_W-1:0]   acc_r, acc_s;
  logic                carry_r, carry_s;
  logic [ADDR_W-1:0]   pc_r, pc_s, pc_inc_s;
  logic [DATA_W:0]     sum_s, diff_s;
  logic                busy_r, done_r, done_s;

  assign op_s     = ir_r[IW-1:DATA_W];
  assign imm_s    = ir_r[DATA_W-1:0];
  assign pc_inc_s = pc_r + PC_ONE;
  assign sum_s    = {1'b0, acc_r} + {1'b0, imm_s};
  assign diff_s   = {1'b0, acc_r} - {1'b0, imm_s};

  // Next-state decode; abort wins over HALT so an aborted EXEC never reports done.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_FETCH;
        else       state_s = S_IDLE;
      end
      S_FETCH: begin
        if (abort) state_s = S_IDLE;
        else       state_s = S_EXEC;
      end
      S_EXEC: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (op_s == 4'b1000) begin
          state_s = S_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = S_FETCH;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Instruction execute: result values committed only at a non-aborted EXEC edge.
  always_comb begin
    acc_s   = acc_r;
    carry_s = carry_r;
    pc_s    = pc_inc_s;
    case (op_s)
      4'b0000: begin acc_s = sum_s[DATA_W-1:0];  carry_s = sum_s[DATA_W];  end
      4'b0001: begin acc_s = diff_s[DATA_W-1:0]; carry_s = diff_s[DATA_W]; end
      4'b0010: begin acc_s = acc_r & imm_s; carry_s = 1'b0; end
      4'b0011: begin acc_s = acc_r | imm_s; carry_s = 1'b0; end
      4'b0100: begin acc_s = acc_r ^ imm_s; carry_s = 1'b0; end
      4'b0101: begin acc_s = ~acc_r;        carry_s = 1'b0; end
      4'b0110: begin acc_s = {acc_r[DATA_W-2:0], 1'b0}; carry_s = acc_r[DATA_W-1]; end
      4'b0111: begin acc_s = {1'b0, acc_r[DATA_W-1:1]}; carry_s = acc_r[0]; end
      4'b1000: pc_s  = pc_r;
      4'b1001: acc_s = imm_s;
`ifdef SEQ_BRANCH_EN
      4'b1010: pc_s = imm_s[ADDR_W-1:0];
      4'b1011: begin
        if (carry_r) pc_s = imm_s[ADDR_W-1:0];
        else         pc_s = pc_inc_s;
      end
`endif
      default: pc_s = pc_inc_s;
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= done_s;
    end
  end

  // Architectural registers: cleared by start, updated at EXEC commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r   <= {DATA_W{1'b0}};
      carry_r <= 1'b0;
      pc_r    <= {ADDR_W{1'b0}};
    end else if ((state_r == S_IDLE) && start) begin
      acc_r   <= {DATA_W{1'b0}};
      carry_r <= 1'b0;
      pc_r    <= {ADDR_W{1'b0}};
    end else if ((state_r == S_EXEC) && !abort) begin
      acc_r   <= acc_s;
      carry_r <= carry_s;
      pc_r    <= pc_s;
    end else begin
      acc_r   <= acc_r;
      carry_r <= carry_r;
      pc_r    <= pc_r;
    end
  end

  // Instruction register loaded by the synchronous memory read in FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_r <= {IW{1'b0}};
    end else if (state_r == S_FETCH) begin
      ir_r <= mem_r[pc_r];
    end else begin
      ir_r <= ir_r;
    end
  end

  // Program memory write port; contents survive reset and are writable only while idle.
  always_ff @(posedge clk) begin
    if (prog_we && (state_r == S_IDLE)) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign acc_out   = acc_r;
  assign carry_out = carry_r;
  assign pc_out    = pc_r;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Self-checking bench for alu_program_sequencer: directed program scenarios plus
// random straight-line programs checked against an instruction-level reference model.
module tb_alu_program_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [11:0] prog_data = 12'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, carry_out;
  logic [7:0]  acc_out;
  logic [3:0]  pc_out;

  int checks = 0;
  int failures = 0;
  logic [11:0] prog [16];

`ifdef SEQ_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  alu_program_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort), .busy(busy),
    .done(done), .acc_out(acc_out), .carry_out(carry_out), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [11:0] w);
    for (int i = 0; i < 16; i++) prog[i] = w;
  endtask

  task automatic load_prog;
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = prog[i];
      tick;
    end
    prog_we = 1'b0;
  endtask

  // Instruction-level interpreter of the program array; n=0 means no HALT reached.
  task automatic model(output int n, output logic [7:0] a, output logic c, output logic [3:0] p);
    int acc, pc, nxt, imm, op;
    bit cy;
    acc = 0; pc = 0; cy = 1'b0; n = 0;
    for (int s = 1; s <= 64 && n == 0; s++) begin
      op  = int'(prog[pc][11:8]);
      imm = int'(prog[pc][7:0]);
      nxt = (pc + 1) % 16;
      case (op)
        0: begin acc = acc + imm; cy = (acc > 255); acc = acc % 256; end
        1: begin cy = (acc < imm); acc = (acc - imm + 256) % 256; end
        2: begin acc = acc & imm; cy = 1'b0; end
        3: begin acc = acc | imm; cy = 1'b0; end
        4: begin acc = acc ^ imm; cy = 1'b0; end
        5: begin acc = 255 - acc; cy = 1'b0; end
        6: begin cy = (acc >= 128); acc = (acc * 2) % 256; end
        7: begin cy = (acc % 2 == 1); acc = acc / 2; end
        8: begin n = s; nxt = pc; end
        9: acc = imm;
        10: if (BR) nxt = imm % 16;
        11: if (BR && cy) nxt = imm % 16;
        default: nxt = (pc + 1) % 16;
      endcase
      pc = nxt;
    end
    a = 8'(acc); c = cy; p = 4'(pc);
  endtask

  // Start the loaded program and check duration, busy, the done pulse and the final state.
  task automatic run(input string tag, input int n, input logic [7:0] a, input logic c, input logic [3:0] p);
    int cyc;
    bit busy_ok;
    start = 1'b1; tick; start = 1'b0;
    busy_ok = (busy === 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      tick; cyc++;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, ".cycles"}, cyc, 2 * n);
    chk({tag, ".busy_during"}, busy_ok, 1);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".acc"}, acc_out, a);
    chk({tag, ".carry"}, carry_out, c);
    chk({tag, ".pc"}, pc_out, p);
    tick;
    chk({tag, ".done_one_cycle"}, done, 0);
  endtask

  initial begin
    int n;
    int h;
    int r;
    bit done_seen;
    logic [7:0] ea;
    logic ec;
    logic [3:0] ep;

    #12;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.acc", acc_out, 0);
    chk("reset.carry", carry_out, 0);
    chk("reset.pc", pc_out, 0);
    rst = 1'b1;
    tick;

    // LOAD 0x80; ADD 0x90; HALT
    fill(12'hC00);
    prog[0] = 12'h980; prog[1] = 12'h090; prog[2] = 12'h800;
    load_prog;
    run("addprog", 3, 8'h10, 1'b1, 4'd2);

    // LOAD 5; SUB 7; SHR; HALT with intermediate observation
    fill(12'hC00);
    prog[0] = 12'h905; prog[1] = 12'h107; prog[2] = 12'h700; prog[3] = 12'h800;
    load_prog;
    start = 1'b1; tick; start = 1'b0;
    repeat (4) tick;
    chk("sub.acc", acc_out, 8'hFE);
    chk("sub.carry", carry_out, 1);
    repeat (2) tick;
    chk("shr.acc", acc_out, 8'h7F);
    chk("shr.carry", carry_out, 0);
    repeat (2) tick;
    chk("shrprog.done", done, 1);
    chk("shrprog.pc", pc_out, 4'd3);
    tick;

    // Branch program
    fill(12'hC00);
    prog[0] = 12'h9FF; prog[1] = 12'h001; prog[2] = 12'hB05; prog[3] = 12'h955;
    prog[4] = 12'h800; prog[5] = 12'h9AA; prog[6] = 12'h800;
    load_prog;
    if (BR) run("branch", 5, 8'hAA, 1'b1, 4'd6);
    else    run("branch", 5, 8'h55, 1'b1, 4'd4);

    // JMP 0 loop, aborted mid-run
    fill(12'hC00);
    prog[0] = 12'hA00;
    load_prog;
    done_seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 21; i++) begin tick; if (done === 1'b1) done_seen = 1'b1; end
    chk("jmploop.busy", busy, 1);
    abort = 1'b1; tick; abort = 1'b0;
    if (done === 1'b1) done_seen = 1'b1;
    chk("jmploop.abort_busy", busy, 0);
    repeat (3) begin tick; if (done === 1'b1) done_seen = 1'b1; end
    chk("jmploop.idle_busy", busy, 0);
    chk("jmploop.no_done", done_seen, 0);

    // 16 NOPs: pc wraps, abort in EXEC does not commit
    fill(12'hC00);
    load_prog;
    start = 1'b1; tick; start = 1'b0;
    repeat (30) tick;
    chk("wrap.pc15", pc_out, 4'd15);
    repeat (2) tick;
    chk("wrap.pc0", pc_out, 4'd0);
    chk("wrap.busy", busy, 1);
    tick;
    abort = 1'b1; tick; abort = 1'b0;
    chk("wrap.abort_busy", busy, 0);
    chk("wrap.abort_done", done, 0);
    chk("wrap.abort_nocommit", pc_out, 4'd0);

    // prog_we and start while busy are ignored
    fill(12'hC00);
    prog[0] = 12'h933; prog[1] = 12'h001; prog[2] = 12'h001; prog[3] = 12'h001;
    prog[4] = 12'h001; prog[5] = 12'h800;
    load_prog;
    start = 1'b1; tick; start = 1'b0;
    repeat (2) tick;
    prog_we = 1'b1; prog_addr = 4'd4; prog_data = 12'h800; start = 1'b1;
    tick;
    prog_we = 1'b0; start = 1'b0;
    n = 3;
    while (done !== 1'b1 && n < 300) begin tick; n++; end
    chk("busywr.cycles", n, 12);
    chk("busywr.acc", acc_out, 8'h37);
    chk("busywr.pc", pc_out, 4'd5);
    tick;

    // Same-cycle write of HALT at 0 plus start
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 12'h800; start = 1'b1;
    tick;
    prog_we = 1'b0; start = 1'b0;
    chk("samecyc.busy", busy, 1);
    tick;
    chk("samecyc.not_yet", done, 0);
    tick;
    chk("samecyc.done", done, 1);
    chk("samecyc.acc", acc_out, 0);
    chk("samecyc.pc", pc_out, 0);
    tick;

    // Async reset during EXEC, then rerun without reloading
    fill(12'hC00);
    prog[0] = 12'h9C3; prog[1] = 12'h011; prog[2] = 12'h600; prog[3] = 12'h1A5;
    prog[4] = 12'h700; prog[5] = 12'h800;
    load_prog;
    model(n, ea, ec, ep);
    start = 1'b1; tick; start = 1'b0;
    repeat (5) tick;
    chk("rstmid.pre_acc_nonzero", (acc_out != 8'h00), 1);
    rst = 1'b0;
    #1;
    chk("rstmid.busy", busy, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.acc", acc_out, 0);
    chk("rstmid.carry", carry_out, 0);
    chk("rstmid.pc", pc_out, 0);
    #1 rst = 1'b1;
    tick;
    run("rerun", n, ea, ec, ep);

    // Random straight-line programs against the reference model
    for (int t = 0; t < 8; t++) begin
      h = int'($urandom_range(3, 15));
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 9));
        if (i == h)      prog[i] = 12'h800;
        else if (i == 0) prog[i] = {4'h9, 8'($urandom)};
        else if (r < 8)  prog[i] = {4'(r), 8'($urandom)};
        else if (r == 8) prog[i] = {4'h9, 8'($urandom)};
        else             prog[i] = {4'hC, 8'($urandom)};
      end
      load_prog;
      model(n, ea, ec, ep);
      run($sformatf("rand%0d", t), n, ea, ec, ep);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
